// File: rtl/x_core_rv32_mc.sv
// rtl/x_core_rv32_mc.sv - multi-cycle RV32I/RV32E core on a single shared memory port
module x_core_rv32_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_data,
    input  logic        i_accept,
    output logic        o_valid,
    output logic        o_rnw,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_be,
    output logic        o_halt,
    output logic [31:0] o_pc
);
    localparam int         RW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state;
    logic [31:0] pc, instr, op_a, op_b, imm;
    logic [1:0]  ea_lo;
    logic [31:0] regs [NREGS];

    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];
    assign o_pc   = pc;

    logic [31:0] dec_imm;
    logic        use_rd, use_rs1, use_rs2, known, dec_illegal;

    // Immediate formation and legality of the held instruction
    always_comb begin
        dec_imm = {{20{instr[31]}}, instr[31:20]};
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        known   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_imm = {instr[31:12], 12'd0};
                use_rd  = 1'b1;
                known   = 1'b1;
            end
            OP_JAL: begin
                dec_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                use_rd  = 1'b1;
                known   = 1'b1;
            end
            OP_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                known  = (f3 == 3'b000);
            end
            OP_BRANCH: begin
                dec_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                known   = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OP_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                known  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                         (f3 == 3'b100) || (f3 == 3'b101);
            end
            OP_STORE: begin
                dec_imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                known   = (f3 <= 3'b010);
            end
            OP_IMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                if (f3 == 3'b001)      known = (f7 == 7'b0000000);
                else if (f3 == 3'b101) known = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   known = 1'b1;
            end
            OP_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                known  = (f7 == 7'b0000000) ||
                         ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OP_FENCE: known = (f3 == 3'b000);
            default:  known = 1'b0;
        endcase
        dec_illegal = !known ||
                      (use_rd  && ({1'b0, rd}  >= NREGS_L)) ||
                      (use_rs1 && ({1'b0, rs1} >= NREGS_L)) ||
                      (use_rs2 && ({1'b0, rs2} >= NREGS_L));
    end

    logic [31:0] alu_b, alu_y, tgt, ea_c, wb_val, nxt_pc, st_data, lane, ld_val;
    logic [3:0]  st_be;
    logic        wb_en, halt_x, is_mem, take;

    // ALU, branch resolution, jump targets and store lane placement
    always_comb begin
        alu_b = (opcode == OP_OP) ? op_b : imm;
        case (f3)
            3'b000:  alu_y = ((opcode == OP_OP) && instr[30]) ? op_a - alu_b : op_a + alu_b;
            3'b001:  alu_y = op_a << alu_b[4:0];
            3'b010:  alu_y = {31'd0, $signed(op_a) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, op_a < alu_b};
            3'b100:  alu_y = op_a ^ alu_b;
            3'b101:  alu_y = instr[30] ? 32'($signed(op_a) >>> alu_b[4:0]) : op_a >> alu_b[4:0];
            3'b110:  alu_y = op_a | alu_b;
            default: alu_y = op_a & alu_b;
        endcase
        case (f3)
            3'b000:  take = (op_a == op_b);
            3'b001:  take = (op_a != op_b);
            3'b100:  take = $signed(op_a) <  $signed(op_b);
            3'b101:  take = $signed(op_a) >= $signed(op_b);
            3'b110:  take = op_a <  op_b;
            3'b111:  take = op_a >= op_b;
            default: take = 1'b0;
        endcase
        ea_c   = op_a + imm;
        tgt    = (opcode == OP_JALR) ? (ea_c & ~32'd1) : pc + imm;
        wb_en  = 1'b0;
        wb_val = alu_y;
        nxt_pc = pc + 32'd4;
        halt_x = 1'b0;
        is_mem = 1'b0;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_val = imm; end
            OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm; end
            OP_JAL, OP_JALR: begin
                if (tgt[1]) halt_x = 1'b1;
                else begin wb_en = 1'b1; wb_val = pc + 32'd4; nxt_pc = tgt; end
            end
            OP_BRANCH: begin
                if (take) begin
                    if (tgt[1]) halt_x = 1'b1;
                    else        nxt_pc = tgt;
                end
            end
            OP_LOAD, OP_STORE: begin
                is_mem = 1'b1;
                halt_x = ((f3[1:0] == 2'b01) && ea_c[0]) ||
                         ((f3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
            end
            OP_IMM, OP_OP: wb_en = 1'b1;
            default: ;
        endcase
        case (f3[1:0])
            2'b00: begin st_be = 4'b0001 << ea_c[1:0];        st_data = {4{op_b[7:0]}}; end
            2'b01: begin st_be = ea_c[1] ? 4'hC : 4'h3;        st_data = {2{op_b[15:0]}}; end
            default: begin st_be = 4'hF;                       st_data = op_b; end
        endcase
        lane = i_data >> {ea_lo, 3'b000};
        case (f3)
            3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_val = {24'd0, lane[7:0]};
            3'b101:  ld_val = {16'd0, lane[15:0]};
            default: ld_val = lane;
        endcase
    end

    // Control FSM with register file and registered bus outputs
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            instr   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            imm     <= '0;
            ea_lo   <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            o_valid <= 1'b1;
            o_rnw   <= 1'b1;
            o_addr  <= {RESET_PC[31:2], 2'b00};
            o_data  <= '0;
            o_be    <= 4'hF;
            o_halt  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (i_accept) begin
                    instr   <= i_data;
                    o_valid <= 1'b0;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        o_halt <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        op_a  <= regs[rs1[RW-1:0]];
                        op_b  <= regs[rs2[RW-1:0]];
                        imm   <= dec_imm;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (halt_x) begin
                        o_halt <= 1'b1;
                        state  <= S_HALT;
                    end else if (is_mem) begin
                        ea_lo   <= ea_c[1:0];
                        o_valid <= 1'b1;
                        o_rnw   <= (opcode == OP_LOAD);
                        o_addr  <= {ea_c[31:2], 2'b00};
                        o_be    <= st_be;
                        o_data  <= (opcode == OP_STORE) ? st_data : 32'd0;
                        state   <= S_MEM;
                    end else begin
                        if (wb_en && (rd != 5'd0)) regs[rd[RW-1:0]] <= wb_val;
                        pc      <= nxt_pc;
                        o_valid <= 1'b1;
                        o_rnw   <= 1'b1;
                        o_addr  <= {nxt_pc[31:2], 2'b00};
                        o_be    <= 4'hF;
                        o_data  <= '0;
                        state   <= S_FETCH;
                    end
                end
                S_MEM: if (i_accept) begin
                    if (o_rnw && (rd != 5'd0)) regs[rd[RW-1:0]] <= ld_val;
                    pc      <= pc + 32'd4;
                    o_valid <= 1'b1;
                    o_rnw   <= 1'b1;
                    o_addr  <= {pc[31:2] + 30'd1, 2'b00};
                    o_be    <= 4'hF;
                    o_data  <= '0;
                    state   <= S_FETCH;
                end
                S_HALT: ;
                default: begin
                    o_valid <= 1'b0;
                    o_halt  <= 1'b1;
                    state   <= S_HALT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_x_core_rv32_mc.sv
// tb/tb_x_core_rv32_mc.sv - directed self-checking bench for x_core_rv32_mc
module tb_x_core_rv32_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] mem [0:255];

    logic        i_nrst = 1'b0;
    logic        bus_en = 1'b1;
    logic        stall_en = 1'b0;
    logic [31:0] stall_addr = 32'h0;
    logic [31:0] i_data, o_addr, o_data, o_pc;
    logic        i_accept, o_valid, o_rnw, o_halt;
    logic [3:0]  o_be;

    assign i_data   = mem[o_addr[9:2]];
    assign i_accept = bus_en && !(stall_en && (o_addr == stall_addr));

    x_core_rv32_mc #(.RESET_PC(32'h100), .NREGS(32)) dut (
        .i_clk(clk), .i_nrst(i_nrst), .i_data(i_data), .i_accept(i_accept),
        .o_valid(o_valid), .o_rnw(o_rnw), .o_addr(o_addr), .o_data(o_data),
        .o_be(o_be), .o_halt(o_halt), .o_pc(o_pc)
    );

    logic        e_nrst = 1'b0;
    logic        e_accept = 1'b1;
    logic [31:0] e_rdata, e_addr, e_wdata, e_pc;
    logic        e_valid, e_rnw, e_halt;
    logic [3:0]  e_be;
    assign e_rdata = mem[e_addr[9:2]];

    x_core_rv32_mc #(.RESET_PC(32'h300), .NREGS(16)) dut_e (
        .i_clk(clk), .i_nrst(e_nrst), .i_data(e_rdata), .i_accept(e_accept),
        .o_valid(e_valid), .o_rnw(e_rnw), .o_addr(e_addr), .o_data(e_wdata),
        .o_be(e_be), .o_halt(e_halt), .o_pc(e_pc)
    );

    typedef struct {
        int          cyc;
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } xfer_t;
    xfer_t xq[$];
    xfer_t sq[$];
    xfer_t lt;
    int          e_st_n = 0;
    logic [31:0] e_st_data = 32'h0;

    // Bus monitor: logs each transfer that will complete on the next edge and applies stores
    always @(negedge clk) begin
        if (i_nrst && o_valid && i_accept) begin
            lt.cyc  = cyc;
            lt.rnw  = o_rnw;
            lt.addr = o_addr;
            lt.data = o_rnw ? i_data : o_data;
            lt.be   = o_be;
            xq.push_back(lt);
            if (!o_rnw) begin
                sq.push_back(lt);
                for (int b = 0; b < 4; b++)
                    if (o_be[b]) mem[o_addr[9:2]][8*b +: 8] = o_data[8*b +: 8];
            end
        end
        if (e_nrst && e_valid && e_accept && !e_rnw) begin
            e_st_n    = e_st_n + 1;
            e_st_data = e_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input int rd, input int rs1, input logic [31:0] imm);
        return {imm[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input int rs1, input int rs2,
                                          input logic [31:0] imm);
        return {imm[11:5], 5'(rs2), 5'(rs1), f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2,
                                          input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'b1101111};
    endfunction

    int wp = 0;
    task automatic emit(input logic [31:0] w);
        mem[wp[9:2]] = w;
        wp = wp + 4;
    endtask
    task automatic li(input int rd, input logic [31:0] v);
        logic [31:0] up;
        up = (v + 32'h800) >> 12;
        emit({up[19:0], 5'(rd), 7'b0110111});
        emit(enc_i(7'b0010011, 3'b000, rd, rd, {20'd0, v[11:0]}));
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        wp = 32'h100;
    endtask
    task automatic do_reset();
        i_nrst = 1'b0;
        repeat (2) @(negedge clk);
        xq.delete();
        sq.delete();
        i_nrst = 1'b1;
    endtask
    task automatic run_to_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!o_halt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halted"}, {31'd0, o_halt}, 32'd1);
    endtask
    function automatic int find_xfer(input logic rnw, input logic [31:0] addr);
        for (int i = 0; i < xq.size(); i++)
            if (xq[i].rnw == rnw && xq[i].addr == addr) return i;
        return -1;
    endfunction

    typedef struct {
        string       name;
        logic        is_imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[15];

    initial begin
        int k;
        int nz;
        logic [31:0] im;

        tbl[0]  = '{"add",   1'b0, 7'h00, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        tbl[1]  = '{"sub",   1'b0, 7'h20, 3'b000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        tbl[2]  = '{"subw",  1'b0, 7'h20, 3'b000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
        tbl[3]  = '{"slt",   1'b0, 7'h00, 3'b010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
        tbl[4]  = '{"sltu",  1'b0, 7'h00, 3'b011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
        tbl[5]  = '{"sra",   1'b0, 7'h20, 3'b101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        tbl[6]  = '{"srl",   1'b0, 7'h00, 3'b101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        tbl[7]  = '{"sll",   1'b0, 7'h00, 3'b001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        tbl[8]  = '{"xor",   1'b0, 7'h00, 3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0};
        tbl[9]  = '{"or",    1'b0, 7'h00, 3'b110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        tbl[10] = '{"and",   1'b0, 7'h00, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00};
        tbl[11] = '{"slti",  1'b1, 7'h00, 3'b010, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'h0000_0001};
        tbl[12] = '{"sltiu", 1'b1, 7'h00, 3'b011, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[13] = '{"srai",  1'b1, 7'h20, 3'b101, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF};
        tbl[14] = '{"andi",  1'b1, 7'h00, 3'b111, 32'h1234_5678, 32'h0000_00FF, 32'h0000_0078};

        // Reset state with the bus refusing: request held at RESET_PC
        clear_mem();
        bus_en = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_valid", {31'd0, o_valid}, 32'd1);
            chk("t1_addr", o_addr, 32'h100);
        end
        chk("t1_rnw", {31'd0, o_rnw}, 32'd1);
        chk("t1_be", {28'd0, o_be}, 32'hF);
        chk("t1_data", o_data, 32'h0);
        chk("t1_halt", {31'd0, o_halt}, 32'd0);
        chk("t1_pc", o_pc, 32'h100);
        chk("t1_nofetch", xq.size(), 32'd0);
        bus_en = 1'b1;
        run_to_halt("t1", 20);
        chk("t1_illegal_pc", o_pc, 32'h100);
        chk("t1_halt_valid", {31'd0, o_valid}, 32'd0);

        // ADDI / SRAI / SLTU results and instruction latency
        clear_mem();
        emit(enc_i(7'b0010011, 3'b000, 1, 0, -1));
        emit(enc_i(7'b0010011, 3'b101, 2, 1, 32'h404));
        emit(enc_r(7'h00, 3'b011, 3, 0, 1));
        emit(enc_s(3'b010, 0, 1, 32'h80));
        emit(enc_s(3'b010, 0, 2, 32'h84));
        emit(enc_s(3'b010, 0, 3, 32'h88));
        do_reset();
        run_to_halt("t2", 100);
        chk("t2_x1", sq[0].data, 32'hFFFF_FFFF);
        chk("t2_x2", sq[1].data, 32'hFFFF_FFFF);
        chk("t2_x3", sq[2].data, 32'h0000_0001);
        chk("t2_lat_addi", 32'(xq[1].cyc - xq[0].cyc), 32'd3);
        chk("t2_lat_srai", 32'(xq[2].cyc - xq[1].cyc), 32'd3);
        chk("t2_lat_sltu", 32'(xq[3].cyc - xq[2].cyc), 32'd3);
        chk("t2_lat_sw", 32'(xq[5].cyc - xq[3].cyc), 32'd4);

        // ALU vectors: operands built with LUI/ADDI, result stored to 0x80
        for (int v = 0; v < 15; v++) begin
            clear_mem();
            li(1, tbl[v].a);
            if (tbl[v].is_imm) begin
                im = ((tbl[v].f3 == 3'b001) || (tbl[v].f3 == 3'b101)) ?
                     {20'd0, tbl[v].f7, tbl[v].b[4:0]} : tbl[v].b;
                emit(enc_i(7'b0010011, tbl[v].f3, 3, 1, im));
            end else begin
                li(2, tbl[v].b);
                emit(enc_r(tbl[v].f7, tbl[v].f3, 3, 1, 2));
            end
            emit(enc_s(3'b010, 0, 3, 32'h80));
            do_reset();
            run_to_halt(tbl[v].name, 100);
            chk(tbl[v].name, sq[0].data, tbl[v].exp);
        end

        // Sub-word stores and loads with lane placement and extension
        clear_mem();
        mem[32'h204 >> 2] = 32'hABCD_8000;
        li(5, 32'h200);
        li(6, 32'h1234_5678);
        emit(enc_s(3'b000, 5, 6, 3));
        emit(enc_i(7'b0000011, 3'b000, 7, 5, 3));
        emit(enc_i(7'b0000011, 3'b000, 8, 5, 5));
        emit(enc_i(7'b0000011, 3'b100, 9, 5, 5));
        emit(enc_i(7'b0000011, 3'b001, 10, 5, 6));
        emit(enc_i(7'b0000011, 3'b101, 11, 5, 6));
        emit(enc_s(3'b001, 5, 6, 6));
        emit(enc_s(3'b010, 0, 7, 32'h80));
        emit(enc_s(3'b010, 0, 8, 32'h84));
        emit(enc_s(3'b010, 0, 9, 32'h88));
        emit(enc_s(3'b010, 0, 10, 32'h8C));
        emit(enc_s(3'b010, 0, 11, 32'h90));
        do_reset();
        run_to_halt("t3", 200);
        chk("t3_sb_addr", sq[0].addr, 32'h200);
        chk("t3_sb_be", {28'd0, sq[0].be}, 32'h8);
        chk("t3_sb_data", sq[0].data, 32'h7878_7878);
        k = find_xfer(1'b0, 32'h200);
        chk("t3_lb_req_rnw", {31'd0, xq[k+2].rnw}, 32'd1);
        chk("t3_lb_req_addr", xq[k+2].addr, 32'h200);
        chk("t3_lb_req_be", {28'd0, xq[k+2].be}, 32'h8);
        chk("t3_lb_rdata", xq[k+2].data, 32'h7800_0000);
        chk("t3_sh_addr", sq[1].addr, 32'h204);
        chk("t3_sh_be", {28'd0, sq[1].be}, 32'hC);
        chk("t3_sh_data", sq[1].data, 32'h5678_5678);
        chk("t3_lb_x7", sq[2].data, 32'h0000_0078);
        chk("t3_lb_neg", sq[3].data, 32'hFFFF_FF80);
        chk("t3_lbu", sq[4].data, 32'h0000_0080);
        chk("t3_lh", sq[5].data, 32'hFFFF_ABCD);
        chk("t3_lhu", sq[6].data, 32'h0000_ABCD);

        // BNE at 0x40 taken and not taken
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            emit(enc_i(7'b0010011, 3'b000, 1, 0, (t == 0) ? 32'd1 : 32'd0));
            emit(enc_j(0, -196));
            mem[32'h38 >> 2] = enc_s(3'b010, 0, 1, 32'h80);
            mem[32'h40 >> 2] = enc_b(3'b001, 0, 1, -8);
            mem[32'h44 >> 2] = enc_s(3'b010, 0, 1, 32'h84);
            do_reset();
            run_to_halt("t4", 100);
            k = find_xfer(1'b1, 32'h40);
            if (t == 0) begin
                chk("t4_taken_next", xq[k+1].addr, 32'h38);
                chk("t4_taken_st", sq[0].addr, 32'h80);
            end else begin
                chk("t4_fall_next", xq[k+1].addr, 32'h44);
                chk("t4_fall_st", sq[0].addr, 32'h84);
            end
        end

        // JALR to a target with bit1 set halts without writing rd
        clear_mem();
        emit(enc_i(7'b0010011, 3'b000, 1, 0, 7));
        emit(enc_j(0, -244));
        mem[32'h10 >> 2] = enc_i(7'b1100111, 3'b000, 1, 0, 3);
        do_reset();
        run_to_halt("t5", 100);
        repeat (3) @(negedge clk);
        chk("t5_valid", {31'd0, o_valid}, 32'd0);
        chk("t5_pc", o_pc, 32'h10);
        chk("t5_x1", dut.regs[1], 32'd7);
        chk("t5_last_xfer", xq[xq.size()-1].addr, 32'h10);

        // Misaligned LW halts before any bus request
        clear_mem();
        emit(enc_i(7'b0010011, 3'b000, 5, 0, 32'h200));
        emit(enc_i(7'b0000011, 3'b010, 6, 5, 2));
        do_reset();
        run_to_halt("t5b", 100);
        repeat (3) @(negedge clk);
        chk("t5b_valid", {31'd0, o_valid}, 32'd0);
        chk("t5b_pc", o_pc, 32'h104);
        chk("t5b_nreq", xq.size(), 32'd2);

        // RV32E: x15 legal, x16 illegal
        mem[32'h300 >> 2] = enc_i(7'b0010011, 3'b000, 15, 0, 5);
        mem[32'h304 >> 2] = enc_s(3'b010, 0, 15, 32'h80);
        mem[32'h308 >> 2] = enc_i(7'b0010011, 3'b000, 16, 0, 1);
        e_nrst = 1'b1;
        k = 0;
        while (!e_halt && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t6_e_halt", {31'd0, e_halt}, 32'd1);
        chk("t6_e_valid", {31'd0, e_valid}, 32'd0);
        chk("t6_e_pc", e_pc, 32'h308);
        chk("t6_e_nstore", e_st_n, 32'd1);
        chk("t6_e_store", e_st_data, 32'd5);

        // Reset while a load waits in MEM
        clear_mem();
        emit(enc_i(7'b0010011, 3'b000, 1, 0, 9));
        emit(enc_i(7'b0000011, 3'b010, 2, 0, 32'h80));
        mem[32'h80 >> 2] = 32'h0000_DEAD;
        stall_en   = 1'b1;
        stall_addr = 32'h80;
        do_reset();
        k = 0;
        while (!(o_valid && o_addr == 32'h80) && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("t6_mem_wait", o_addr, 32'h80);
        chk("t6_x1_before", dut.regs[1], 32'd9);
        i_nrst = 1'b0;
        #1;
        chk("t6_rst_addr", o_addr, 32'h100);
        chk("t6_rst_rnw", {31'd0, o_rnw}, 32'd1);
        chk("t6_rst_pc", o_pc, 32'h100);
        nz = 0;
        for (int r = 0; r < 32; r++) if (dut.regs[r] != 32'd0) nz++;
        chk("t6_rst_regs", nz, 32'd0);
        stall_en = 1'b0;
        @(negedge clk);
        xq.delete();
        sq.delete();
        i_nrst = 1'b1;
        run_to_halt("t6b", 100);
        chk("t6_restart", xq[0].addr, 32'h100);
        chk("t6_x2_load", dut.regs[2], 32'h0000_DEAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
